// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// This is the receive half of the 8N1 UART link. It samples the asynchronous rx
// line on clk and recovers each frame. A frame is one start bit, eight data bits
// sent LSB first, and one stop bit. The received byte is handed to the
// downstream matrix-load logic through a valid/ack holding register.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   data       last good byte; holds until the next good frame
//   valid      high while data holds an unacknowledged byte
//   ack        consumer takes data this cycle; ignored while valid=0
//   overrun    sticky; set when a new byte replaces an unacknowledged one
//   frame_err  one-cycle pulse when the stop bit samples 0
//   busy       high whenever the receiver is not idle
//
// Parameter
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;

    // rx_m/rx_s form the two-flop synchronizer; rx_p lags rx_s by one cycle
    // so a falling edge on the synchronized line can be seen.
    logic rx_m, rx_s, rx_p;

    logic stop_good;
    logic stop_bad;

    // ---- synchronizer / edge detect ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    // ---- frame FSM: next state ----
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        case (state)
            IDLE: begin
                // Only a real 1->0 transition starts a frame. This stops a
                // line that stays low after a bad stop bit from starting a
                // frame again and again.
                if (rx_p && !rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    // If the line is high again at mid start bit, the low
                    // pulse was a glitch, not a start bit.
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    stop_good = rx_s;
                    stop_bad  = !rx_s;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // ---- frame FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            // busy is registered from the next state. It therefore matches
            // the state register exactly and does not add a cycle of lag.
            busy  <= (state_nxt != IDLE);
        end
    end

    // ---- holding register / status ----
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (stop_good) begin
                data  <= shift;
                valid <= 1'b1;
                // An ack in the same cycle consumes the old byte, so
                // replacing it is not an overrun.
                if (valid && !ack) begin
                    overrun <= 1'b1;
                end else if (valid && ack) begin
                    overrun <= 1'b0;
                end
            end else if (valid && ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int CPB    = 16;
    localparam int H      = CPB / 2;
    // Edge index (counted from the first edge with rx low) of the stop sample.
    localparam int STOP_E = H + 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference model of the consumer-visible registers.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ack       (ack),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {7'b0, obs}, {7'b0, exp});
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".data"}, data, m_data);
        check1({tag, ".valid"}, valid, m_valid);
        check1({tag, ".overrun"}, overrun, m_ovr);
    endtask

    // Drive one full frame. n counts edges from E0, the first edge with rx
    // low. When ack_stop is set, ack is high on the stop-sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int n = 0; n < 10 * CPB; n++) begin
            rx  = bits[n / CPB];
            ack = ack_stop && (n == STOP_E);
            tick();
            check1("frame.busy", busy, (n >= 2) && (n < STOP_E));
            if (n == STOP_E) begin
                if (stop) begin
                    if (m_valid && !ack_stop) m_ovr = 1'b1;
                    else if (m_valid && ack_stop) m_ovr = 1'b0;
                    m_data  = b;
                    m_valid = 1'b1;
                end else if (m_valid && ack_stop) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
                check_regs("stop");
                check1("stop.frame_err", frame_err, !stop);
            end else begin
                check1("frame.frame_err", frame_err, 1'b0);
            end
        end
        ack = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        ack = 1'b0;
        check_regs("ack");
    endtask

    task automatic glitch(input int len);
        for (int n = 0; n < 2 * CPB; n++) begin
            rx = (n < len) ? 1'b0 : 1'b1;
            tick();
            check1("glitch.busy", busy, (n >= 2) && (n < H + 2));
            check1("glitch.frame_err", frame_err, 1'b0);
        end
        check_regs("glitch");
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] rb;
        logic       ra;

        rst     = 1'b1;
        rx      = 1'b1;
        ack     = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;

        // Reset state
        repeat (3) tick();
        check_regs("reset");
        check1("reset.busy", busy, 1'b0);
        check1("reset.frame_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        // Basic frame
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) tick();
        check_regs("a5.after");
        check1("a5.busy", busy, 1'b0);
        ack_pulse();

        // Short low glitch
        glitch(4);

        // Bad stop bit, then the line stays low
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check1("low.busy", busy, 1'b0);
            check1("low.frame_err", frame_err, 1'b0);
        end
        check_regs("low");
        rx = 1'b1;
        repeat (4) tick();
        check1("high.busy", busy, 1'b0);
        send_frame(8'h77, 1'b1, 1'b0);
        ack_pulse();

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_regs("ovr");
        ack_pulse();

        // Back-to-back with ack on the second stop sample
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        check_regs("b2b");
        ack_pulse();

        // Random bytes with random ack timing
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            send_frame(rb, 1'b1, ra);
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end
        ack_pulse();

        // Reset in the middle of data bit 4 of 0x5A
        bits = {1'b1, 8'h5A, 1'b0};
        for (int n = 0; n < 5 * CPB + H; n++) begin
            rx = bits[n / CPB];
            tick();
        end
        check1("mid.busy", busy, 1'b1);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check_regs("midrst");
        check1("midrst.busy", busy, 1'b0);
        rst = 1'b0;
        repeat (12 * CPB) tick();
        check_regs("discard");
        check1("discard.busy", busy, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        repeat (4) tick();
        check_regs("c3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
